// File: rtl/rx_burst_scheduler.sv
// ============================================================================
// rx_burst_scheduler -- grants one RX channel FIFO a burst of up to BURST_MAX
// words onto the shared BRAM FIFO write port, then rotates.   Rev 1.0
// ============================================================================
`default_nettype none

module rx_burst_scheduler #(
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       BUS_CLK,
  input  logic                       BUS_RST_N,
  input  logic [WIDTH-1:0]           ENABLE,
  input  logic [WIDTH-1:0]           WRITE_REQ,
  input  logic [WIDTH*32-1:0]        DATA_IN,
  output logic [WIDTH-1:0]           READ_GRANT,
  input  logic                       READY_IN,
  output logic                       WRITE_OUT,
  output logic [31:0]                DATA_OUT,
  output logic [2:0]                 CURRENT_CH,
  output logic                       BUSY,
  input  logic                       CNT_CLR,
  output logic [WIDTH*CNT_WIDTH-1:0] WORD_CNT
);

  localparam logic [7:0]           c_BURST_MAX = 8'(BURST_MAX);
  localparam logic [2:0]           c_LAST_INIT = 3'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_ch;
  logic [2:0]  r_last;
  logic [7:0]  r_burst_cnt;
  logic        r_write_out;
  logic [31:0] r_data_out;

  logic [WIDTH-1:0] w_req;
  logic [WIDTH-1:0] w_grant;
  logic             w_ch_req;
  logic [31:0]      w_ch_data;
  logic             w_pop;
  logic             w_found;
  logic [2:0]       w_next_ch;
  int               w_dist;
  int               w_best;

  assign w_req = WRITE_REQ & ENABLE;

  always_comb begin
    w_ch_req  = 1'b0;
    w_ch_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_ch == 3'(i)) begin
        w_ch_req  = w_req[i];
        w_ch_data = DATA_IN[32*i +: 32];
      end
    end
  end

  assign w_pop = (r_state == ST_GRANT) && w_ch_req && READY_IN;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_grant[i] = w_pop && (r_ch == 3'(i));
    end
  end

  // Rotating priority: distance 0 is the channel just after the last granted one.
  always_comb begin
    w_found   = 1'b0;
    w_next_ch = '0;
    w_best    = WIDTH;
    w_dist    = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dist = (i + WIDTH - 1 - int'(r_last)) % WIDTH;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_next_ch = 3'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_last      <= c_LAST_INIT;
      r_burst_cnt <= '0;
      r_write_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_write_out <= w_pop;
      if (w_pop) begin
        r_data_out <= w_ch_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_ch        <= w_next_ch;
            r_burst_cnt <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A stall (READY_IN low with data present) holds everything.
          if (!w_ch_req) begin
            r_state <= ST_SWITCH;
          end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
            if ((r_burst_cnt + 8'd1) == c_BURST_MAX) begin
              r_state <= ST_SWITCH;
            end
          end
        end
        ST_SWITCH: begin
          r_last  <= r_ch;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
          r_cnt <= '0;
        end else if (CNT_CLR) begin
          r_cnt <= w_grant[gi] ? c_CNT_ONE : '0;
        end else if (w_grant[gi] && (r_cnt != c_CNT_MAX)) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
      assign WORD_CNT[CNT_WIDTH*gi +: CNT_WIDTH] = r_cnt;
    end
  endgenerate

  assign READ_GRANT = w_grant;
  assign WRITE_OUT  = r_write_out;
  assign DATA_OUT   = r_data_out;
  assign CURRENT_CH = r_ch;
  assign BUSY       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_burst_scheduler.sv
// ============================================================================
// tb_rx_burst_scheduler -- directed bench with FWFT channel FIFO models and a
// write scoreboard.   Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rx_burst_scheduler;

  localparam int W   = 4;
  localparam int BM  = 16;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic            BUS_CLK = 1'b0;
  logic            BUS_RST_N = 1'b0;
  logic [W-1:0]    ENABLE = '1;
  logic [W-1:0]    WRITE_REQ = '0;
  logic [W*32-1:0] DATA_IN = '0;
  logic            READY_IN = 1'b1;
  logic            CNT_CLR = 1'b0;

  logic [W-1:0]    read_grant,   s_read_grant;
  logic            write_out,    s_write_out;
  logic [31:0]     data_out,     s_data_out;
  logic [2:0]      current_ch,   s_current_ch;
  logic            busy,         s_busy;
  logic [W*CW-1:0] word_cnt;
  logic [W*CWS-1:0] s_word_cnt;

  rx_burst_scheduler #(.WIDTH(W), .BURST_MAX(BM), .CNT_WIDTH(CW)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE), .WRITE_REQ(WRITE_REQ),
    .DATA_IN(DATA_IN), .READ_GRANT(read_grant), .READY_IN(READY_IN), .WRITE_OUT(write_out),
    .DATA_OUT(data_out), .CURRENT_CH(current_ch), .BUSY(busy), .CNT_CLR(CNT_CLR),
    .WORD_CNT(word_cnt)
  );

  // Narrow-counter instance for the saturation case; shares all inputs.
  rx_burst_scheduler #(.WIDTH(W), .BURST_MAX(BM), .CNT_WIDTH(CWS)) dut_sat (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE), .WRITE_REQ(WRITE_REQ),
    .DATA_IN(DATA_IN), .READ_GRANT(s_read_grant), .READY_IN(READY_IN), .WRITE_OUT(s_write_out),
    .DATA_OUT(s_data_out), .CURRENT_CH(s_current_ch), .BUSY(s_busy), .CNT_CLR(CNT_CLR),
    .WORD_CNT(s_word_cnt)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_checks = 0;
  int n_errors = 0;

  int rem [W];
  int head [W];
  int pops_ch [W];
  logic [31:0] exp_q [$];
  int b_ch [$];
  int b_len [$];
  int b_gap [$];
  int e_ch [8];
  int e_len [8];
  int e_gap [8];
  int since_pop = 0;
  int writes = 0;
  int viol = 0;
  int quiet = 0;
  bit idle_seen = 1'b1;
  bit toggle_ready = 1'b0;
  bit drop_armed = 1'b0;
  bit clr_armed = 1'b0;
  bit clr_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tag_word(input int ch, input int n);
    return {4'hC, 4'(ch), 24'(n)};
  endfunction

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      WRITE_REQ[i]         = (rem[i] > 0);
      DATA_IN[32*i +: 32]  = tag_word(i, head[i]);
    end
  endtask

  // One clock cycle: monitor at the falling edge, update FIFO models after the rising edge.
  task automatic step();
    logic [W-1:0] g;
    int ch;
    @(negedge BUS_CLK);
    g  = read_grant;
    ch = -1;
    if (write_out) begin
      writes++;
      chk("write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("data_out", data_out, exp_q.pop_front());
    end
    if (g != '0) begin
      if ($countones(g) != 1) viol++;
      for (int i = 0; i < W; i++) begin
        if (g[i]) begin
          if (!((rem[i] > 0) && ENABLE[i] && READY_IN)) viol++;
          exp_q.push_back(tag_word(i, head[i]));
          ch = i;
        end
      end
      if (idle_seen || (b_ch.size() == 0) || (b_ch[b_ch.size()-1] != ch)) begin
        b_ch.push_back(ch);
        b_len.push_back(1);
        b_gap.push_back(since_pop);
      end else begin
        b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
      end
      idle_seen = 1'b0;
      since_pop = 0;
      if (clr_armed) begin
        CNT_CLR     = 1'b1;
        clr_armed   = 1'b0;
        clr_pending = 1'b1;
      end
    end else begin
      since_pop++;
    end
    if (!busy) idle_seen = 1'b1;
    quiet = (!busy && !write_out && (g == '0)) ? quiet + 1 : 0;
    @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < W; i++) begin
      if (g[i]) begin
        rem[i]--;
        head[i]++;
        pops_ch[i]++;
      end
    end
    if (clr_pending) begin
      CNT_CLR     = 1'b0;
      clr_pending = 1'b0;
      chk("cnt_clr_on_pop", 32'(word_cnt[CW*1 +: CW]), 32'd1);
      chk("cnt_clr_on_pop_sat", 32'(s_word_cnt[CWS*1 +: CWS]), 32'd1);
    end
    if (drop_armed && (pops_ch[1] == 5)) begin
      ENABLE[1]  = 1'b0;
      drop_armed = 1'b0;
    end
    if (toggle_ready) READY_IN = ~READY_IN;
    drive();
  endtask

  task automatic run_quiet(input string t, input int maxc);
    int n;
    n = 0;
    quiet = 0;
    while ((quiet < 4) && (n < maxc)) begin
      step();
      n++;
    end
    chk({t, "_finished"}, 32'(quiet >= 4), 32'd1);
    chk({t, "_no_lost_write"}, 32'(exp_q.size()), 32'd0);
    chk({t, "_protocol"}, 32'(viol), 32'd0);
  endtask

  task automatic check_bursts(input string t, input int n);
    chk({t, "_nbursts"}, 32'(b_ch.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < b_ch.size()) begin
        chk($sformatf("%s_burst%0d_ch", t, k), 32'(b_ch[k]), 32'(e_ch[k]));
        chk($sformatf("%s_burst%0d_len", t, k), 32'(b_len[k]), 32'(e_len[k]));
        if (e_gap[k] >= 0) chk($sformatf("%s_burst%0d_gap", t, k), 32'(b_gap[k]), 32'(e_gap[k]));
      end
    end
  endtask

  task automatic do_reset();
    BUS_RST_N = 1'b0;
    for (int i = 0; i < W; i++) begin
      rem[i]     = 0;
      pops_ch[i] = 0;
    end
    exp_q.delete();
    b_ch.delete();
    b_len.delete();
    b_gap.delete();
    ENABLE       = '1;
    READY_IN     = 1'b1;
    CNT_CLR      = 1'b0;
    toggle_ready = 1'b0;
    drop_armed   = 1'b0;
    clr_armed    = 1'b0;
    clr_pending  = 1'b0;
    idle_seen    = 1'b1;
    since_pop    = 0;
    writes       = 0;
    viol         = 0;
    drive();
    repeat (2) @(posedge BUS_CLK);
    #1;
    BUS_RST_N = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < W; i++) head[i] = i * 1000;

    // Reset values
    do_reset();
    BUS_RST_N = 1'b0;
    #2;
    chk("rst_write_out", 32'(write_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_current_ch", 32'(current_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_grant", 32'(read_grant), 32'd0);
    chk("rst_word_cnt0", 32'(word_cnt[0 +: CW]), 32'd0);

    // 1: single requester, 40 words -> 16, 16, 8
    do_reset();
    rem[0] = 40;
    drive();
    run_quiet("t1", 300);
    e_ch = '{0, 0, 0, 0, 0, 0, 0, 0};
    e_len = '{16, 16, 8, 0, 0, 0, 0, 0};
    e_gap = '{-1, 2, 2, 0, 0, 0, 0, 0};
    check_bursts("t1", 3);
    chk("t1_word_cnt0", 32'(word_cnt[0 +: CW]), 32'd40);
    chk("t1_writes", 32'(writes), 32'd40);

    // 2: all channels 20 words
    do_reset();
    for (int i = 0; i < W; i++) rem[i] = 20;
    drive();
    run_quiet("t2", 500);
    e_ch = '{0, 1, 2, 3, 0, 1, 2, 3};
    e_len = '{16, 16, 16, 16, 4, 4, 4, 4};
    e_gap = '{-1, 2, 2, 2, 2, 3, 3, 3};
    check_bursts("t2", 8);
    chk("t2_writes", 32'(writes), 32'd80);
    chk("t2_word_cnt3", 32'(word_cnt[CW*3 +: CW]), 32'd20);

    // 3: READY_IN toggling during ch2 bursts
    do_reset();
    rem[2] = 20;
    toggle_ready = 1'b1;
    drive();
    run_quiet("t3", 500);
    e_ch = '{2, 2, 0, 0, 0, 0, 0, 0};
    e_len = '{16, 4, 0, 0, 0, 0, 0, 0};
    e_gap = '{-1, -1, 0, 0, 0, 0, 0, 0};
    check_bursts("t3", 2);
    chk("t3_writes", 32'(writes), 32'd20);
    chk("t3_word_cnt2", 32'(word_cnt[CW*2 +: CW]), 32'd20);

    // 4: ch2 disabled, ch1 disabled after its 5th pop
    do_reset();
    ENABLE = 4'b1011;
    for (int i = 0; i < W; i++) rem[i] = 20;
    drop_armed = 1'b1;
    drive();
    run_quiet("t4", 500);
    e_ch = '{0, 1, 3, 0, 3, 0, 0, 0};
    e_len = '{16, 5, 16, 4, 4, 0, 0, 0};
    e_gap = '{-1, 2, 3, 2, 3, 0, 0, 0};
    check_bursts("t4", 5);
    chk("t4_word_cnt0", 32'(word_cnt[CW*0 +: CW]), 32'd20);
    chk("t4_word_cnt1", 32'(word_cnt[CW*1 +: CW]), 32'd5);
    chk("t4_word_cnt2", 32'(word_cnt[CW*2 +: CW]), 32'd0);
    chk("t4_word_cnt3", 32'(word_cnt[CW*3 +: CW]), 32'd20);

    // 5: counter saturation and clear
    do_reset();
    rem[1] = 20;
    drive();
    run_quiet("t5a", 300);
    chk("t5_sat_cnt1", 32'(s_word_cnt[CWS*1 +: CWS]), 32'd15);
    chk("t5_wide_cnt1", 32'(word_cnt[CW*1 +: CW]), 32'd20);
    rem[1] = 3;
    clr_armed = 1'b1;
    drive();
    run_quiet("t5b", 100);
    chk("t5_after_clr_cnt1", 32'(word_cnt[CW*1 +: CW]), 32'd3);
    chk("t5_after_clr_sat_cnt1", 32'(s_word_cnt[CWS*1 +: CWS]), 32'd3);
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    chk("t5_plain_clr_cnt1", 32'(word_cnt[CW*1 +: CW]), 32'd0);

    // 6: asynchronous reset mid-burst on ch3
    do_reset();
    rem[3] = 20;
    drive();
    n = 0;
    while ((pops_ch[3] < 5) && (n < 100)) begin
      step();
      n++;
    end
    chk("t6_reached_pop5", 32'(pops_ch[3]), 32'd5);
    chk("t6_inflight_write", 32'(write_out), 32'd1);
    chk("t6_ch_before_rst", 32'(current_ch), 32'd3);
    #2;
    BUS_RST_N = 1'b0;
    #1;
    chk("t6_rst_write_out", 32'(write_out), 32'd0);
    chk("t6_rst_data_out", data_out, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_current_ch", 32'(current_ch), 32'd0);
    chk("t6_rst_read_grant", 32'(read_grant), 32'd0);
    chk("t6_rst_word_cnt3", 32'(word_cnt[CW*3 +: CW]), 32'd0);
    exp_q.delete();
    b_ch.delete();
    b_len.delete();
    b_gap.delete();
    idle_seen = 1'b1;
    rem[0] = 10;
    drive();
    @(posedge BUS_CLK);
    #1;
    BUS_RST_N = 1'b1;
    run_quiet("t6", 300);
    e_ch = '{0, 3, 0, 0, 0, 0, 0, 0};
    e_len = '{10, 15, 0, 0, 0, 0, 0, 0};
    e_gap = '{-1, -1, 0, 0, 0, 0, 0, 0};
    check_bursts("t6", 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
